// File: rtl/realtime_mux_config_sequencer.sv
// realtime_mux_config_sequencer
//
// Holds a software-loaded table of mux selection words. Each hardware trigger
// issues the next word on the config stream, so the downstream channel mux
// steps through a schedule of channel mappings without processor involvement.
// Sits upstream of the mux's config CDC and runs entirely in the clk domain.
//
// Ports
//   clk, reset        sole clock; asynchronous active-high reset
//   table_*           table load stream (slave); last marks the final entry
//   trigger           single-cycle advance request
//   config_*          selection word stream (master); channel k occupies
//                     bits [k*SELECT_BITS +: SELECT_BITS]; last tied to 1
//   index             entry the next trigger will send
//   length            number of valid table entries (0 = no table)
//   wrap              one-cycle pulse when index returns to 0 after a send
//   trigger_overrun   sticky; a trigger arrived with one already pending
//
// state | meaning
// IDLE  | no valid table (length 0) or a table load is in progress
// ARMED | table valid, waiting for a trigger
// SEND  | config_valid high, waiting for the handshake

module realtime_mux_config_sequencer #(
  parameter int OUTPUT_CHANNELS = 8,
  parameter int INPUT_CHANNELS  = 16,
  parameter int DEPTH           = 16,
  localparam int SELECT_BITS    = $clog2(INPUT_CHANNELS),
  localparam int CONFIG_WIDTH   = OUTPUT_CHANNELS * SELECT_BITS,
  localparam int IDX_W          = $clog2(DEPTH),
  localparam int LEN_W          = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [CONFIG_WIDTH-1:0] table_data,
  input  logic                    table_valid,
  input  logic                    table_last,
  output logic                    table_ready,
  input  logic                    trigger,
  output logic [CONFIG_WIDTH-1:0] config_data,
  output logic                    config_valid,
  input  logic                    config_ready,
  output logic                    config_last,
  output logic [IDX_W-1:0]        index,
  output logic [LEN_W-1:0]        length,
  output logic                    wrap,
  output logic                    trigger_overrun
);

  typedef enum logic [1:0] {IDLE, ARMED, SEND} state_t;

  state_t                  state;
  logic [IDX_W-1:0]        wptr;
  logic                    pending;
  logic [CONFIG_WIDTH-1:0] mem [DEPTH];

  logic                    accept;
  logic                    table_full;
  logic [LEN_W-1:0]        wptr_inc;
  logic [LEN_W-1:0]        idx_inc;
  logic [IDX_W-1:0]        next_idx;

  // Loads are refused while a word is in flight, so a table entry is never
  // read in the same cycle it is written.
  assign table_ready = (state != SEND) && !reset;
  assign accept      = table_valid && table_ready;
  assign config_last = 1'b1;

  assign table_full = (wptr == IDX_W'(DEPTH - 1));
  assign wptr_inc   = LEN_W'(wptr) + LEN_W'(1);
  assign idx_inc    = LEN_W'(index) + LEN_W'(1);
  assign next_idx   = (idx_inc == length) ? '0 : idx_inc[IDX_W-1:0];

  // Table storage carries no reset: a fresh table must be loaded after reset
  // anyway, and length 0 keeps stale contents from ever being sent.
  always_ff @(posedge clk) begin
    if (accept) mem[wptr] <= table_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      wptr            <= '0;
      pending         <= 1'b0;
      index           <= '0;
      length          <= '0;
      config_data     <= '0;
      config_valid    <= 1'b0;
      wrap            <= 1'b0;
      trigger_overrun <= 1'b0;
    end else begin
      wrap <= 1'b0;
      case (state)
        IDLE, ARMED: begin
          // A load takes priority over a trigger arriving in the same cycle.
          if (accept) begin
            if (wptr == '0) index <= '0;
            if (table_last || table_full) begin
              length <= wptr_inc;
              wptr   <= '0;
              state  <= ARMED;
            end else begin
              if (wptr == '0) length <= '0;
              wptr  <= wptr + IDX_W'(1);
              state <= IDLE;
            end
          end else if (state == ARMED && trigger) begin
            config_data  <= mem[index];
            config_valid <= 1'b1;
            state        <= SEND;
          end
        end

        SEND: begin
          if (config_ready) begin
            index <= next_idx;
            wrap  <= (next_idx == '0);
            if (pending || trigger) begin
              // Back-to-back: the follow-on word goes out on the next cycle.
              // A fresh trigger alongside a consumed pending one stays queued.
              config_data <= mem[next_idx];
              pending     <= pending && trigger;
            end else begin
              config_valid <= 1'b0;
              state        <= ARMED;
            end
          end else if (trigger) begin
            if (pending) trigger_overrun <= 1'b1;
            else         pending         <= 1'b1;
          end
        end

        default: begin
          state        <= IDLE;
          config_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_realtime_mux_config_sequencer.sv
module tb_realtime_mux_config_sequencer;

  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [CW-1:0] tdata;
  logic          tvalid, tlast, tready;
  logic          trigger;
  logic [CW-1:0] cdata;
  logic          cvalid, cready, clast;
  logic [3:0]    index;
  logic [4:0]    length;
  logic          wrap, overrun;

  int n_cmp = 0;
  int n_err = 0;

  logic [CW-1:0] hs_q[$];
  logic [CW-1:0] w [16];
  int            wrap_cnt = 0;

  realtime_mux_config_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .table_data      (tdata),
    .table_valid     (tvalid),
    .table_last      (tlast),
    .table_ready     (tready),
    .trigger         (trigger),
    .config_data     (cdata),
    .config_valid    (cvalid),
    .config_ready    (cready),
    .config_last     (clast),
    .index           (index),
    .length          (length),
    .wrap            (wrap),
    .trigger_overrun (overrun)
  );

  always #5 clk = ~clk;

  // Record every completed transfer and every wrap pulse seen at a clock edge.
  always @(posedge clk) begin
    if (!reset && cvalid && cready) hs_q.push_back(cdata);
    if (!reset && wrap) wrap_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Streams n words from w[]; last on the final word if set_last; trigger held
  // at trig for every load cycle.
  task automatic load(input int n, input bit set_last, input bit trig);
    for (int i = 0; i < n; i++) begin
      tvalid  = 1'b1;
      tdata   = w[i];
      tlast   = set_last && (i == n - 1);
      trigger = trig;
      n_cmp++;
      if (tready !== 1'b1) begin
        n_err++;
        $display("FAIL load_ready word %0d: got %b want 1", i, tready);
      end
      step();
    end
    tvalid  = 1'b0;
    tlast   = 1'b0;
    trigger = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    n_cmp++; if (cvalid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", cvalid); end
    n_cmp++; if (cdata !== '0) begin n_err++; $display("FAIL rst_data: got %h want 0", cdata); end
    n_cmp++; if (index !== 4'd0) begin n_err++; $display("FAIL rst_index: got %0d want 0", index); end
    n_cmp++; if (length !== 5'd0) begin n_err++; $display("FAIL rst_length: got %0d want 0", length); end
    n_cmp++; if (wrap !== 1'b0) begin n_err++; $display("FAIL rst_wrap: got %b want 0", wrap); end
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL rst_overrun: got %b want 0", overrun); end
    n_cmp++; if (tready !== 1'b0) begin n_err++; $display("FAIL rst_tready: got %b want 0", tready); end
    n_cmp++; if (clast !== 1'b1) begin n_err++; $display("FAIL clast: got %b want 1", clast); end
    step(); step();
    reset = 1'b0;
    step();
    n_cmp++; if (tready !== 1'b1) begin n_err++; $display("FAIL idle_tready: got %b want 1", tready); end
  endtask

  task automatic test_no_table();
    for (int i = 0; i < 3; i++) begin
      trigger = 1'b1;
      step();
      trigger = 1'b0;
      step();
      n_cmp++; if (cvalid !== 1'b0) begin n_err++; $display("FAIL notable_valid %0d: got %b want 0", i, cvalid); end
    end
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL notable_overrun: got %b want 0", overrun); end
    n_cmp++; if (hs_q.size() !== 0) begin n_err++; $display("FAIL notable_hs: got %0d want 0", hs_q.size()); end
  endtask

  task automatic test_sequence();
    logic [CW-1:0] exp_d [4];
    logic [3:0]    exp_i [4];
    logic          exp_w [4];
    int            w0;
    w[0] = 32'h7654_3210; w[1] = 32'hFEDC_BA98; w[2] = 32'h0F1E_2D3C;
    exp_d = '{32'h7654_3210, 32'hFEDC_BA98, 32'h0F1E_2D3C, 32'h7654_3210};
    exp_i = '{4'd1, 4'd2, 4'd0, 4'd1};
    exp_w = '{1'b0, 1'b0, 1'b1, 1'b0};
    hs_q.delete();
    cready = 1'b1;
    // Trigger held through the load, including the cycle last is accepted.
    load(3, 1'b1, 1'b1);
    n_cmp++; if (cvalid !== 1'b0) begin n_err++; $display("FAIL trig_at_last_valid: got %b want 0", cvalid); end
    n_cmp++; if (length !== 5'd3) begin n_err++; $display("FAIL seq_length: got %0d want 3", length); end
    step();
    n_cmp++; if (cvalid !== 1'b0) begin n_err++; $display("FAIL trig_at_last_valid2: got %b want 0", cvalid); end
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL trig_at_last_overrun: got %b want 0", overrun); end
    w0 = wrap_cnt;
    for (int i = 0; i < 4; i++) begin
      trigger = 1'b1;
      step();
      trigger = 1'b0;
      n_cmp++; if (cvalid !== 1'b1) begin n_err++; $display("FAIL seq_valid %0d: got %b want 1", i, cvalid); end
      n_cmp++; if (cdata !== exp_d[i]) begin n_err++; $display("FAIL seq_data %0d: got %h want %h", i, cdata, exp_d[i]); end
      step();
      n_cmp++; if (cvalid !== 1'b0) begin n_err++; $display("FAIL seq_drop %0d: got %b want 0", i, cvalid); end
      n_cmp++; if (index !== exp_i[i]) begin n_err++; $display("FAIL seq_index %0d: got %0d want %0d", i, index, exp_i[i]); end
      n_cmp++; if (wrap !== exp_w[i]) begin n_err++; $display("FAIL seq_wrap %0d: got %b want %b", i, wrap, exp_w[i]); end
      repeat (8) step();
    end
    n_cmp++; if (wrap_cnt - w0 !== 1) begin n_err++; $display("FAIL seq_wrap_count: got %0d want 1", wrap_cnt - w0); end
    n_cmp++; if (hs_q.size() !== 4) begin n_err++; $display("FAIL seq_hs_count: got %0d want 4", hs_q.size()); end
  endtask

  task automatic test_stall();
    w[0] = 32'hAAAA_0001; w[1] = 32'hBBBB_0002; w[2] = 32'hCCCC_0003;
    cready = 1'b0;
    load(3, 1'b1, 1'b0);
    hs_q.delete();
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    n_cmp++; if (cvalid !== 1'b1 || cdata !== 32'hAAAA_0001) begin n_err++; $display("FAIL stall_first: got %b/%h want 1/aaaa0001", cvalid, cdata); end
    for (int i = 0; i < 5; i++) begin
      trigger = (i == 1) || (i == 3);
      step();
      trigger = 1'b0;
      n_cmp++; if (cdata !== 32'hAAAA_0001 || cvalid !== 1'b1) begin n_err++; $display("FAIL stall_hold %0d: got %b/%h want 1/aaaa0001", i, cvalid, cdata); end
      n_cmp++; if (overrun !== (i >= 3)) begin n_err++; $display("FAIL stall_overrun %0d: got %b want %b", i, overrun, (i >= 3)); end
    end
    cready = 1'b1;
    step();
    n_cmp++; if (cvalid !== 1'b1 || cdata !== 32'hBBBB_0002) begin n_err++; $display("FAIL stall_b2b: got %b/%h want 1/bbbb0002", cvalid, cdata); end
    n_cmp++; if (index !== 4'd1) begin n_err++; $display("FAIL stall_idx1: got %0d want 1", index); end
    step();
    n_cmp++; if (cvalid !== 1'b0 || index !== 4'd2) begin n_err++; $display("FAIL stall_end: got %b/%0d want 0/2", cvalid, index); end
    n_cmp++;
    if (hs_q.size() !== 2) begin
      n_err++; $display("FAIL stall_hs_count: got %0d want 2", hs_q.size());
    end else if (hs_q[0] !== 32'hAAAA_0001 || hs_q[1] !== 32'hBBBB_0002) begin
      n_err++; $display("FAIL stall_hs_order: got %h,%h want aaaa0001,bbbb0002", hs_q[0], hs_q[1]);
    end
    n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL overrun_sticky: got %b want 1", overrun); end
  endtask

  task automatic test_depth();
    for (int i = 0; i < 16; i++) w[i] = 32'hD000_0000 + i;
    cready = 1'b1;
    load(16, 1'b0, 1'b0);
    n_cmp++; if (length !== 5'd16) begin n_err++; $display("FAIL depth_length: got %0d want 16", length); end
    n_cmp++; if (index !== 4'd0) begin n_err++; $display("FAIL depth_index: got %0d want 0", index); end
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    n_cmp++; if (cvalid !== 1'b1 || cdata !== 32'hD000_0000) begin n_err++; $display("FAIL depth_armed_send: got %b/%h want 1/d0000000", cvalid, cdata); end
    step();
    n_cmp++; if (index !== 4'd1) begin n_err++; $display("FAIL depth_idx_after: got %0d want 1", index); end
    w[0] = 32'h1234_ABCD;
    load(1, 1'b1, 1'b0);
    n_cmp++; if (length !== 5'd1 || index !== 4'd0) begin n_err++; $display("FAIL depth_17th: got len %0d idx %0d want 1/0", length, index); end
    for (int i = 0; i < 2; i++) begin
      trigger = 1'b1;
      step();
      trigger = 1'b0;
      n_cmp++; if (cvalid !== 1'b1 || cdata !== 32'h1234_ABCD) begin n_err++; $display("FAIL len1_data %0d: got %b/%h want 1/1234abcd", i, cvalid, cdata); end
      step();
      n_cmp++; if (wrap !== 1'b1 || index !== 4'd0) begin n_err++; $display("FAIL len1_wrap %0d: got %b/%0d want 1/0", i, wrap, index); end
      repeat (3) step();
    end
  endtask

  task automatic test_reload_mid();
    int hs0;
    for (int i = 0; i < 4; i++) w[i] = 32'h4400_0000 + i;
    cready = 1'b1;
    load(4, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      trigger = 1'b1; step(); trigger = 1'b0; step();
    end
    n_cmp++; if (index !== 4'd2) begin n_err++; $display("FAIL reload_pre_idx: got %0d want 2", index); end
    hs0 = hs_q.size();
    w[0] = 32'hE000_0000; w[1] = 32'hE000_0001;
    load(2, 1'b1, 1'b1);
    n_cmp++; if (cvalid !== 1'b0) begin n_err++; $display("FAIL reload_valid: got %b want 0", cvalid); end
    n_cmp++; if (length !== 5'd2 || index !== 4'd0) begin n_err++; $display("FAIL reload_state: got len %0d idx %0d want 2/0", length, index); end
    step();
    n_cmp++; if (hs_q.size() !== hs0) begin n_err++; $display("FAIL reload_no_send: got %0d want %0d", hs_q.size(), hs0); end
    for (int i = 0; i < 2; i++) begin
      trigger = 1'b1; step(); trigger = 1'b0;
      n_cmp++; if (cdata !== (32'hE000_0000 + i)) begin n_err++; $display("FAIL reload_data %0d: got %h want %h", i, cdata, 32'hE000_0000 + i); end
      step();
      n_cmp++; if (index !== ((i == 0) ? 4'd1 : 4'd0) || wrap !== (i == 1)) begin n_err++; $display("FAIL reload_idx %0d: got %0d/%b", i, index, wrap); end
    end
  endtask

  task automatic test_reset_mid_send();
    int hs0;
    cready = 1'b0;
    trigger = 1'b1; step(); trigger = 1'b0;
    n_cmp++; if (cvalid !== 1'b1) begin n_err++; $display("FAIL rms_pre_valid: got %b want 1", cvalid); end
    hs0 = hs_q.size();
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (cvalid !== 1'b0) begin n_err++; $display("FAIL rms_valid: got %b want 0", cvalid); end
    n_cmp++; if (length !== 5'd0 || index !== 4'd0) begin n_err++; $display("FAIL rms_len_idx: got %0d/%0d want 0/0", length, index); end
    n_cmp++; if (tready !== 1'b0) begin n_err++; $display("FAIL rms_tready: got %b want 0", tready); end
    cready = 1'b1;
    step(); step();
    reset = 1'b0;
    trigger = 1'b1; step(); trigger = 1'b0; step();
    n_cmp++; if (cvalid !== 1'b0) begin n_err++; $display("FAIL rms_no_table: got %b want 0", cvalid); end
    n_cmp++; if (hs_q.size() !== hs0) begin n_err++; $display("FAIL rms_no_hs: got %0d want %0d", hs_q.size(), hs0); end
  endtask

  initial begin
    reset   = 1'b1;
    tdata   = '0;
    tvalid  = 1'b0;
    tlast   = 1'b0;
    trigger = 1'b0;
    cready  = 1'b1;
    test_reset();
    test_no_table();
    test_sequence();
    test_stall();
    test_depth();
    test_reload_mid();
    test_reset_mid_send();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
